// File: rtl/moving_avg_pkg.sv
// moving_avg_pkg: default widths, derived constants and sign-extension helper for the boxcar filter
package moving_avg_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LOG2_TAPS = 3;
  localparam int DEF_TAPS = 2 ** DEF_LOG2_TAPS;
  localparam int DEF_ACC_W = DEF_DATA_W + DEF_LOG2_TAPS;
  function automatic logic signed [DEF_ACC_W-1:0] sext(input logic signed [DEF_DATA_W-1:0] x);
    return DEF_ACC_W'(x);
  endfunction
endpackage

// File: rtl/sample_delay_line.sv
// sample_delay_line: TAPS-deep shift register of samples exposing the oldest entry
module sample_delay_line #(
  parameter int DATA_W = 16,
  parameter int TAPS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] data_in,
  output logic signed [DATA_W-1:0] oldest
);
  logic [TAPS-1:0][DATA_W-1:0] sr;
  // new sample enters entry 0, everything moves one step older
  always_ff @(posedge clk or posedge reset)
    if (reset) sr <= '0;
    else sr <= {sr[TAPS-2:0], data_in};
  assign oldest = sr[TAPS-1];
endmodule

// File: rtl/moving_avg_fir.sv
// moving_avg_fir: streaming running-sum boxcar average over the last 2**LOG2_TAPS samples
module moving_avg_fir
  import moving_avg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LOG2_TAPS = DEF_LOG2_TAPS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] data_in,
  output logic signed [DATA_W-1:0] data_out
);
  localparam int TAPS = 2 ** LOG2_TAPS;
  localparam int ACC_W = DATA_W + LOG2_TAPS;
  logic signed [DATA_W-1:0] oldest;
  logic signed [ACC_W-1:0] acc, acc_next;
  sample_delay_line #(.DATA_W(DATA_W), .TAPS(TAPS)) u_dl (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .oldest(oldest)
  );
  // window sum after admitting the new sample and retiring the oldest one
  always_comb acc_next = acc + ACC_W'(data_in) - ACC_W'(oldest);
  // running sum and floor-divided mean; the mean always fits DATA_W so truncation is lossless
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= '0;
      data_out <= '0;
    end else begin
      acc <= acc_next;
      data_out <= DATA_W'(acc_next >>> LOG2_TAPS);
    end
endmodule

// File: tb/tb_moving_avg_fir.sv
// tb_moving_avg_fir: table-driven directed vectors plus async-reset sine sequence against a window model
module tb_moving_avg_fir;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [15:0] data_in = '0;
  logic signed [15:0] data_out;
  int errors = 0;
  int checks = 0;
  int hist[8];
  typedef struct {
    string nm;
    logic rst;
    int din;
    int exp;
  } vec_t;
  vec_t v[$];

  moving_avg_fir dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void add(input string nm, input logic r, input int d, input int e);
    vec_t x;
    x.nm = nm;
    x.rst = r;
    x.din = d;
    x.exp = e;
    v.push_back(x);
  endfunction

  function automatic int floor8(input int s);
    int q;
    q = s / 8;
    if (s < 0 && (s % 8) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int model_push(input int x);
    int s;
    s = x;
    for (int i = 7; i > 0; i--) begin
      hist[i] = hist[i-1];
      s += hist[i];
    end
    hist[0] = x;
    return s;
  endfunction

  function automatic int sine(input int i);
    int q[9] = '{0, 29, 57, 83, 106, 125, 139, 147, 150};
    int k, r;
    k = i % 16;
    r = (k <= 8) ? q[k] : q[16-k];
    return ((i % 32) >= 16) ? -r : r;
  endfunction

  initial begin
    int s, idx;
    int ramp[8] = '{-24577, -16385, -8193, -1, 8191, 16383, 24575, 32767};
    for (int i = 0; i < 5; i++) add("reset_hold", 1'b1, 123, 0);
    for (int i = 1; i <= 10; i++) add("step", 1'b0, 80, (i < 8 ? i : 8) * 10);
    for (int i = 1; i <= 8; i++) add("step_down", 1'b0, 0, 80 - 10 * i);
    add("imp_pos", 1'b0, 100, 12);
    for (int i = 0; i < 7; i++) add("imp_pos", 1'b0, 0, 12);
    add("imp_pos_end", 1'b0, 0, 0);
    add("imp_neg", 1'b0, -100, -13);
    for (int i = 0; i < 7; i++) add("imp_neg", 1'b0, 0, -13);
    add("imp_neg_end", 1'b0, 0, 0);
    add("reset_alt", 1'b1, 55, 0);
    for (int i = 0; i < 12; i++)
      add("alt", 1'b0, (i % 2 == 0) ? 100 : -100, (i < 8 && i % 2 == 0) ? 12 : 0);
    add("reset_ext", 1'b1, -7, 0);
    for (int i = 1; i <= 10; i++) add("min", 1'b0, -32768, -4096 * (i < 8 ? i : 8));
    for (int i = 0; i < 8; i++) add("ramp", 1'b0, 32767, ramp[i]);
    add("max_hold", 1'b0, 32767, 32767);
    add("max_hold", 1'b0, 32767, 32767);
    reset = 1'b1;
    data_in = 16'sd123;
    #1;
    chk("reset_initial", int'(data_out), 0);
    foreach (v[i]) begin
      reset = v[i].rst;
      data_in = 16'(v[i].din);
      @(posedge clk);
      #1;
      chk(v[i].nm, int'(data_out), v[i].exp);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    foreach (hist[i]) hist[i] = 0;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      data_in = 16'(sine(idx));
      s = model_push(sine(idx));
      idx++;
      @(posedge clk);
      #1;
      chk("sine_out", int'(data_out), floor8(s));
      chk("sine_acc", int'(dut.acc), s);
    end
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_out", int'(data_out), 0);
    chk("async_rst_acc", int'(dut.acc), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_out", int'(data_out), 0);
    reset = 1'b0;
    foreach (hist[i]) hist[i] = 0;
    for (int c = 0; c < 40; c++) begin
      data_in = 16'(sine(idx));
      s = model_push(sine(idx));
      idx++;
      @(posedge clk);
      #1;
      chk("sine_post_out", int'(data_out), floor8(s));
      chk("sine_post_acc", int'(dut.acc), s);
      chk("sine_range", int'(data_out >= -16'sd150 && data_out <= 16'sd150), 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
